// File: rtl/ex_if.sv
// ID/EX bundle, EX/MEM entry and pipeline control for the execute stage.
// The master side drives the bundle; the slave side (ex_stage) drives the entry.
interface ex_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc_in;
  logic [XLEN-1:0] rs1_data_in;
  logic [XLEN-1:0] rs2_data_in;
  logic [XLEN-1:0] imm_in;
  logic [4:0]      write_reg_in;
  logic [9:0]      alu_control_in;
  logic            alusrc_in;
  logic            branch_in;
  logic            memwrite_in;
  logic            memread_in;
  logic            memtoreg_in;
  logic            regwrite_in;
  logic            stall_in;
  logic            flush_in;

  logic            out_valid;
  logic [XLEN-1:0] alu_result_out;
  logic [XLEN-1:0] store_data_out;
  logic [4:0]      write_reg_out;
  logic            memwrite_out;
  logic            memread_out;
  logic            memtoreg_out;
  logic            regwrite_out;
  logic            branch_taken_out;
  logic [XLEN-1:0] branch_target_out;
  logic            inv_func_out;

  modport master (
    output in_valid, pc_in, rs1_data_in, rs2_data_in, imm_in, write_reg_in,
           alu_control_in, alusrc_in, branch_in, memwrite_in, memread_in,
           memtoreg_in, regwrite_in, stall_in, flush_in,
    input  in_ready, out_valid, alu_result_out, store_data_out, write_reg_out,
           memwrite_out, memread_out, memtoreg_out, regwrite_out,
           branch_taken_out, branch_target_out, inv_func_out
  );

  modport slave (
    input  in_valid, pc_in, rs1_data_in, rs2_data_in, imm_in, write_reg_in,
           alu_control_in, alusrc_in, branch_in, memwrite_in, memread_in,
           memtoreg_in, regwrite_in, stall_in, flush_in,
    output in_ready, out_valid, alu_result_out, store_data_out, write_reg_out,
           memwrite_out, memread_out, memtoreg_out, regwrite_out,
           branch_taken_out, branch_target_out, inv_func_out
  );
endinterface

// File: rtl/ex_stage.sv
// RISC-V execute stage: ALU, BEQ resolution and an iterative shift-add multiplier
// that back-pressures decode while it runs, all feeding the EX/MEM register.
module ex_stage #(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  ex_if.slave  bus
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] res_s;
  logic [SW-1:0]   shamt_s;
  logic            eq_s;
  logic            inv_s;
  logic            is_mul_s;
  logic            in_ready_s;
  logic            load_s;
  logic [XLEN-1:0] mul_a_r;
  logic [XLEN-1:0] mul_b_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mul_store_r;
  logic [XLEN-1:0] mul_target_r;
  logic [CW-1:0]   cnt_r;
  logic [4:0]      mul_rd_r;
  logic            mul_regwrite_r;
  logic            mul_memtoreg_r;

  assign in_ready_s   = (state_r == IDLE) && !bus.stall_in;
  assign bus.in_ready = in_ready_s;
  // A bundle offered in a flush cycle is killed rather than executed.
  assign load_s       = bus.in_valid && in_ready_s && !bus.flush_in;

  // Operand select and single-cycle ALU decode
  always_comb begin
    op_b_s   = bus.alusrc_in ? bus.imm_in : bus.rs2_data_in;
    shamt_s  = op_b_s[SW-1:0];
    eq_s     = (bus.rs1_data_in == bus.rs2_data_in);
    res_s    = {XLEN{1'b0}};
    inv_s    = 1'b0;
    is_mul_s = 1'b0;
    if (bus.memread_in || bus.memwrite_in) begin
      res_s = bus.rs1_data_in + op_b_s;
    end else if (bus.branch_in) begin
      res_s = {{(XLEN-1){1'b0}}, eq_s};
    end else begin
      case (bus.alu_control_in)
        10'b0000000_000: res_s = bus.rs1_data_in + op_b_s;
        10'b0100000_000: res_s = bus.rs1_data_in - op_b_s;
        10'b0000000_001: res_s = bus.rs1_data_in << shamt_s;
        10'b0000000_010: res_s = {{(XLEN-1){1'b0}}, ($signed(bus.rs1_data_in) < $signed(op_b_s))};
        10'b0000000_100: res_s = bus.rs1_data_in ^ op_b_s;
        10'b0000000_101: res_s = bus.rs1_data_in >> shamt_s;
        10'b0100000_101: res_s = $signed(bus.rs1_data_in) >>> shamt_s;
        10'b0000000_110: res_s = bus.rs1_data_in | op_b_s;
        10'b0000000_111: res_s = bus.rs1_data_in & op_b_s;
        10'b0000001_000: begin
          if (MUL_EN) begin
            is_mul_s = 1'b1;
          end else begin
            inv_s = 1'b1;
          end
        end
        default: inv_s = 1'b1;
      endcase
    end
  end

  // Multiplier state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Multiplier next state; flush aborts, stall only delays the DONE hand-off
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s && is_mul_s) begin
          state_nxt_s = BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.flush_in) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == CW'(XLEN - 1)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        if (bus.flush_in || !bus.stall_in) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Shift-add datapath and the MUL's captured control fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a_r        <= {XLEN{1'b0}};
      mul_b_r        <= {XLEN{1'b0}};
      acc_r          <= {XLEN{1'b0}};
      cnt_r          <= {CW{1'b0}};
      mul_store_r    <= {XLEN{1'b0}};
      mul_target_r   <= {XLEN{1'b0}};
      mul_rd_r       <= 5'd0;
      mul_regwrite_r <= 1'b0;
      mul_memtoreg_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (load_s && is_mul_s) begin
        mul_a_r        <= bus.rs1_data_in;
        mul_b_r        <= op_b_s;
        acc_r          <= {XLEN{1'b0}};
        cnt_r          <= {CW{1'b0}};
        mul_store_r    <= bus.rs2_data_in;
        mul_target_r   <= bus.pc_in + bus.imm_in;
        mul_rd_r       <= bus.write_reg_in;
        mul_regwrite_r <= bus.regwrite_in;
        mul_memtoreg_r <= bus.memtoreg_in;
      end
    end else if (state_r == BUSY) begin
      if (mul_b_r[0]) begin
        acc_r <= acc_r + mul_a_r;
      end
      mul_a_r <= mul_a_r << 1;
      mul_b_r <= mul_b_r >> 1;
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  // EX/MEM register: flush beats stall, stall holds, otherwise entry or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid         <= 1'b0;
      bus.alu_result_out    <= {XLEN{1'b0}};
      bus.store_data_out    <= {XLEN{1'b0}};
      bus.write_reg_out     <= 5'd0;
      bus.memwrite_out      <= 1'b0;
      bus.memread_out       <= 1'b0;
      bus.memtoreg_out      <= 1'b0;
      bus.regwrite_out      <= 1'b0;
      bus.branch_taken_out  <= 1'b0;
      bus.branch_target_out <= {XLEN{1'b0}};
      bus.inv_func_out      <= 1'b0;
    end else if (bus.flush_in || (!bus.stall_in && (state_r != DONE) && !(load_s && !is_mul_s))) begin
      bus.out_valid        <= 1'b0;
      bus.memwrite_out     <= 1'b0;
      bus.memread_out      <= 1'b0;
      bus.memtoreg_out     <= 1'b0;
      bus.regwrite_out     <= 1'b0;
      bus.branch_taken_out <= 1'b0;
      bus.inv_func_out     <= 1'b0;
    end else if (bus.stall_in) begin
      bus.out_valid <= bus.out_valid;
    end else if (state_r == DONE) begin
      bus.out_valid         <= 1'b1;
      bus.alu_result_out    <= acc_r;
      bus.store_data_out    <= mul_store_r;
      bus.write_reg_out     <= mul_rd_r;
      bus.memwrite_out      <= 1'b0;
      bus.memread_out       <= 1'b0;
      bus.memtoreg_out      <= mul_memtoreg_r;
      bus.regwrite_out      <= mul_regwrite_r;
      bus.branch_taken_out  <= 1'b0;
      bus.branch_target_out <= mul_target_r;
      bus.inv_func_out      <= 1'b0;
    end else begin
      bus.out_valid         <= 1'b1;
      bus.alu_result_out    <= res_s;
      bus.store_data_out    <= bus.rs2_data_in;
      bus.write_reg_out     <= bus.write_reg_in;
      bus.memwrite_out      <= bus.memwrite_in && !bus.branch_in;
      bus.memread_out       <= bus.memread_in && !bus.branch_in;
      bus.memtoreg_out      <= bus.memtoreg_in;
      bus.regwrite_out      <= bus.regwrite_in && !bus.branch_in && !inv_s;
      bus.branch_taken_out  <= bus.branch_in && eq_s;
      bus.branch_target_out <= bus.pc_in + bus.imm_in;
      bus.inv_func_out      <= inv_s;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases plus randomized traffic with
// stall/flush, checked against a plain-arithmetic reference model.
module tb_ex_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_if #(.XLEN(XLEN)) bus ();
  ex_stage #(.XLEN(XLEN), .MUL_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic [9:0]  ctrl;
    logic        alusrc, branch, memwrite, memread, memtoreg, regwrite;
  } op_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] res, store;
    logic [4:0]  rd;
    logic        regwrite, memwrite, memread, memtoreg, taken;
    logic [63:0] target;
    logic        inv;
  } ent_t;

  localparam logic [9:0] CODES [9] = '{10'b0000000_000, 10'b0100000_000, 10'b0000000_001,
                                       10'b0000000_010, 10'b0000000_100, 10'b0000000_101,
                                       10'b0100000_101, 10'b0000000_110, 10'b0000000_111};

  ent_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference behaviour straight from the ISA rules
  function automatic ent_t model(input op_t o);
    ent_t e;
    logic [63:0] b;
    b = o.alusrc ? o.imm : o.rs2;
    e = '0;
    e.valid = 1'b1;
    e.store = o.rs2;
    e.rd = o.rd;
    e.target = o.pc + o.imm;
    e.memtoreg = o.memtoreg;
    if (o.memread || o.memwrite) begin
      e.res = o.rs1 + b;
      e.regwrite = o.regwrite;
      e.memwrite = o.memwrite;
      e.memread = o.memread;
    end else if (o.branch) begin
      e.taken = (o.rs1 == o.rs2);
      e.res = e.taken ? 64'd1 : 64'd0;
    end else begin
      e.regwrite = o.regwrite;
      case (o.ctrl)
        10'b0000000_000: e.res = o.rs1 + b;
        10'b0100000_000: e.res = o.rs1 - b;
        10'b0000000_001: e.res = o.rs1 << b[5:0];
        10'b0000000_010: e.res = ($signed(o.rs1) < $signed(b)) ? 64'd1 : 64'd0;
        10'b0000000_100: e.res = o.rs1 ^ b;
        10'b0000000_101: e.res = o.rs1 >> b[5:0];
        10'b0100000_101: e.res = $signed(o.rs1) >>> b[5:0];
        10'b0000000_110: e.res = o.rs1 | b;
        10'b0000000_111: e.res = o.rs1 & b;
        10'b0000001_000: e.res = o.rs1 * b;
        default: begin
          e.res = 64'd0;
          e.regwrite = 1'b0;
          e.inv = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  function automatic ent_t sample();
    ent_t s;
    s.valid = bus.out_valid;
    s.res = bus.alu_result_out;
    s.store = bus.store_data_out;
    s.rd = bus.write_reg_out;
    s.regwrite = bus.regwrite_out;
    s.memwrite = bus.memwrite_out;
    s.memread = bus.memread_out;
    s.memtoreg = bus.memtoreg_out;
    s.taken = bus.branch_taken_out;
    s.target = bus.branch_target_out;
    s.inv = bus.inv_func_out;
    return s;
  endfunction

  function automatic op_t mk(input logic [9:0] ctrl, input logic [63:0] a, input logic [63:0] b);
    op_t o;
    o = '0;
    o.ctrl = ctrl;
    o.rs1 = a;
    o.rs2 = b;
    o.rd = 5'd3;
    o.regwrite = 1'b1;
    return o;
  endfunction

  function automatic logic [63:0] rnd64();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 20));
    return {$urandom, $urandom};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    o = '0;
    o.pc = {$urandom, $urandom};
    o.rs1 = rnd64();
    o.rs2 = rnd64();
    o.imm = rnd64();
    o.rd = 5'($urandom_range(0, 31));
    o.regwrite = 1'($urandom_range(0, 1));
    o.memtoreg = 1'($urandom_range(0, 1));
    o.alusrc = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 19);
    if (k < 4) begin
      o.memread = (k < 2);
      o.memwrite = (k >= 2);
    end else if (k < 7) begin
      o.branch = 1'b1;
      if (k == 4) o.rs2 = o.rs1;
    end else if (k < 9) begin
      o.ctrl = 10'($urandom);
    end else if (k == 9) begin
      o.ctrl = 10'b0000001_000;
    end else begin
      o.ctrl = CODES[$urandom_range(0, 8)];
    end
    return o;
  endfunction

  // One cycle of upstream drive; records the expected entry if the bundle is taken
  task automatic drive_cycle(input logic v, input op_t o, input logic st, input logic fl, output logic acc);
    @(negedge clk);
    bus.in_valid = v;
    bus.pc_in = o.pc;
    bus.rs1_data_in = o.rs1;
    bus.rs2_data_in = o.rs2;
    bus.imm_in = o.imm;
    bus.write_reg_in = o.rd;
    bus.alu_control_in = o.ctrl;
    bus.alusrc_in = o.alusrc;
    bus.branch_in = o.branch;
    bus.memwrite_in = o.memwrite;
    bus.memread_in = o.memread;
    bus.memtoreg_in = o.memtoreg;
    bus.regwrite_in = o.regwrite;
    bus.stall_in = st;
    bus.flush_in = fl;
    #1;
    acc = v && bus.in_ready && !fl;
    if (acc) exp_q.push_back(model(o));
  endtask

  task automatic issue(input op_t o);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      drive_cycle(1'b1, o, 1'b0, 1'b0, acc);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL issue_timeout: in_ready never seen after %0d cycles, required within 300", n);
    end
  endtask

  // Monitor: every non-stalled edge yields either a new entry or a bubble
  initial begin
    ent_t prev, cur;
    logic st, fl;
    prev = '0;
    forever begin
      @(posedge clk);
      st = bus.stall_in;
      fl = bus.flush_in;
      #1;
      cur = sample();
      if (!rst) begin
        if (fl) begin
          check("flush_bubble", 256'({cur.valid, cur.regwrite, cur.memwrite, cur.memread, cur.taken}), 256'(5'b0));
        end else if (st) begin
          check("stall_hold", 256'(cur), 256'(prev));
        end else if (cur.valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry: got %0h expected no entry", cur);
          end else begin
            check("entry", 256'(cur), 256'(exp_q.pop_front()));
          end
        end else begin
          check("bubble", 256'({cur.regwrite, cur.memwrite, cur.memread, cur.taken, cur.inv}), 256'(5'b0));
        end
      end
      prev = cur;
    end
  end

  initial begin
    op_t o, nop;
    ent_t snap;
    logic acc, st, fl, have;
    int cnt;
    nop = '0;
    bus.in_valid = 1'b0; bus.pc_in = '0; bus.rs1_data_in = '0; bus.rs2_data_in = '0;
    bus.imm_in = '0; bus.write_reg_in = 5'd0; bus.alu_control_in = 10'd0; bus.alusrc_in = 1'b0;
    bus.branch_in = 1'b0; bus.memwrite_in = 1'b0; bus.memread_in = 1'b0; bus.memtoreg_in = 1'b0;
    bus.regwrite_in = 1'b0; bus.stall_in = 1'b0; bus.flush_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 256'(bus.in_ready), 256'(1'b1));
    check("reset_outputs", 256'(sample()), 256'(0));

    issue(mk(10'b0000000_000, 64'd5, 64'd7));
    @(posedge clk); #1;
    check("add_result", 256'(bus.alu_result_out), 256'(64'd12));
    check("add_valid_regwrite", 256'({bus.out_valid, bus.regwrite_out}), 256'(2'b11));

    issue(mk(10'b0100000_101, 64'hFFFF_FFFF_FFFF_FF00, 64'd4));
    @(posedge clk); #1;
    check("sra_result", 256'(bus.alu_result_out), 256'(64'hFFFF_FFFF_FFFF_FFF0));
    issue(mk(10'b0100000_000, 64'd0, 64'd1));
    @(posedge clk); #1;
    check("sub_result", 256'(bus.alu_result_out), 256'(64'hFFFF_FFFF_FFFF_FFFF));

    o = mk(10'b0000000_000, 64'd9, 64'd9);
    o.branch = 1'b1; o.pc = 64'h100; o.imm = 64'h20;
    issue(o);
    @(posedge clk); #1;
    check("beq_taken", 256'({bus.branch_taken_out, bus.regwrite_out}), 256'(2'b10));
    check("beq_target", 256'(bus.branch_target_out), 256'(64'h120));
    drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    check("beq_pulse_end", 256'(bus.branch_taken_out), 256'(1'b0));
    o.rs2 = 64'd8;
    issue(o);
    @(posedge clk); #1;
    check("beq_not_taken", 256'(bus.branch_taken_out), 256'(1'b0));

    issue(mk(10'b0000001_000, 64'd6, 64'd7));
    cnt = 0;
    do begin
      drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);
      if (!bus.in_ready) cnt++;
    end while (!bus.in_ready && cnt < 200);
    check("mul_busy_cycles", 256'(cnt), 256'(XLEN + 1));
    check("mul_result", 256'({bus.out_valid, bus.alu_result_out}), 256'({1'b1, 64'd42}));
    issue(mk(10'b0000001_000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3));
    cnt = 0;
    do begin
      drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);
      cnt++;
    end while (!bus.in_ready && cnt < 200);
    check("mul_neg_result", 256'(bus.alu_result_out), 256'(64'hFFFF_FFFF_FFFF_FFFD));

    issue(mk(10'b0000000_000, 64'd10, 64'd20));
    @(posedge clk); #1;
    snap = sample();
    repeat (3) drive_cycle(1'b0, nop, 1'b1, 1'b0, acc);
    @(posedge clk); #1;
    check("stall_3_hold", 256'(sample()), 256'(snap));
    drive_cycle(1'b0, nop, 1'b1, 1'b1, acc);
    @(posedge clk); #1;
    check("flush_over_stall", 256'({bus.out_valid, bus.regwrite_out, bus.memwrite_out, bus.memread_out}), 256'(4'b0));
    drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);

    issue(mk(10'b1111111_000, 64'd3, 64'd4));
    @(posedge clk); #1;
    check("invalid_func", 256'({bus.inv_func_out, bus.alu_result_out, bus.regwrite_out}), 256'({1'b1, 64'd0, 1'b0}));

    issue(mk(10'b0000001_000, 64'd5, 64'd5));
    repeat (10) drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_mid_mul_outputs", 256'(sample()), 256'(0));
    check("reset_mid_mul_ready", 256'(bus.in_ready), 256'(1'b1));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;

    have = 1'b0;
    o = nop;
    for (int n = 0; n < 800; n++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        o = rand_op();
        have = 1'b1;
      end
      st = ($urandom_range(0, 7) == 0);
      fl = (exp_q.size() == 0) && ($urandom_range(0, 15) == 0);
      drive_cycle(have, o, st, fl, acc);
      if (acc) have = 1'b0;
    end
    repeat (80) drive_cycle(1'b0, nop, 1'b0, 1'b0, acc);
    check("queue_drained", 256'(exp_q.size()), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
